// File: rtl/py_acl_pkg.sv
// -----------------------------------------------------------------------------
// py_acl_pkg
// Shared definitions for the ACL payload buffer controllers (transmit and
// receive side): SRAM geometry, payload length width and the transmit
// buffer FSM state encoding.
// -----------------------------------------------------------------------------
package py_acl_pkg;

    // SRAM word address width and resulting depth (256 x 32 banks)
    localparam int ACL_AW         = 8;
    localparam int ACL_SRAM_DEPTH = 1 << ACL_AW;
    localparam int ACL_DW         = 32;

    // Payload length width in bytes
    localparam int ACL_LW         = 10;

    // Transmit buffer FSM
    //   ST_IDLE     : tx bank empty, waiting for a filled bank
    //   ST_READY    : tx bank holds a packet the encoder may send
    //   ST_WAIT_ACK : packet sent, waiting for the peer's ARQN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READY    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } acl_tx_state_e;

endpackage : py_acl_pkg

// File: rtl/sram256x32_1p.sv
// -----------------------------------------------------------------------------
// sram256x32_1p
// 256 x 32 single-port synchronous SRAM model (infers block RAM).
// One access per cycle: write when cs & we, registered read when cs & !we.
// Ports:
//   clk   clock
//   cs    chip select
//   we    write enable (qualified by cs)
//   addr  word address
//   din   write data
//   dout  read data, valid the cycle after a read access, held otherwise
// -----------------------------------------------------------------------------
module sram256x32_1p (
    input  logic        clk,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [31:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule : sram256x32_1p

// File: rtl/py_tx_acl_buf_ctrl.sv
// -----------------------------------------------------------------------------
// py_tx_acl_buf_ctrl
// Transmit-side ACL payload buffer. Two 256x32 SRAM banks run ping-pong:
// the baseband state machine fills one bank while the link controller reads
// the other (the tx bank) during packet encoding. The tx bank is held until
// the peer acknowledges it through ARQN; NAK or a missing response leads to
// retransmission. Also tracks SEQN and the buffer status bits.
//
// Optional build macro: TXACL_FLUSH_EN
//   Adds regi_flushto (flush timeout in slot pairs, 0 = off) and flush_p.
//   A packet not acknowledged within regi_flushto RX slots is dropped as if
//   it had been acknowledged.
//
// Ports:
//   clk_6M             6 MHz baseband clock
//   rst                synchronous active-high reset
//   bsm_addr/din/we    fill-bank write port
//   bsm_wr_done_p      fill bank complete, length on bsm_pylenByte
//   lnctrl_addr/cs     tx-bank read port, data on lnctrl_dout one cycle later
//   lnctrl_tx_done_p   encoder consumed the last payload word
//   pk_encode          1 = TX slot, 0 = RX slot
//   ms_tslot_p         slot boundary pulse
//   dec_hecgood/arqn   received header status and ARQN bit
//   txbuf_valid        tx bank holds a packet ready to send
//   tx_pylenByte       tx-bank payload length (0 when empty)
//   tx_seqn, tx_retx   SEQN of outgoing packet, retransmission flag
//   regi_acltxbufempty both banks empty
//   regi_acltxbuffull  both banks full
// -----------------------------------------------------------------------------
module py_tx_acl_buf_ctrl
    import py_acl_pkg::*;
#(
    parameter int AW = ACL_AW,
    parameter int LW = ACL_LW
) (
    input  logic          clk_6M,
    input  logic          rst,
    input  logic [AW-1:0] bsm_addr,
    input  logic [31:0]   bsm_din,
    input  logic          bsm_we,
    input  logic          bsm_wr_done_p,
    input  logic [LW-1:0] bsm_pylenByte,
    input  logic [AW-1:0] lnctrl_addr,
    input  logic          lnctrl_cs,
    input  logic          lnctrl_tx_done_p,
    input  logic          pk_encode,
    input  logic          ms_tslot_p,
    input  logic          dec_hecgood,
    input  logic          dec_arqn,
`ifdef TXACL_FLUSH_EN
    input  logic [15:0]   regi_flushto,
    output logic          flush_p,
`endif
    output logic [31:0]   lnctrl_dout,
    output logic          txbuf_valid,
    output logic [LW-1:0] tx_pylenByte,
    output logic          tx_seqn,
    output logic          tx_retx,
    output logic          regi_acltxbufempty,
    output logic          regi_acltxbuffull
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    acl_tx_state_e state_q, state_d;
    logic          txsel_q, txsel_d;
    logic [1:0]    full_q, full_d;
    logic [LW-1:0] len_q [2];
    logic [LW-1:0] len_d [2];
    logic          seqn_q, seqn_d;
    logic          retx_q, retx_d;
    logic          valid_q, valid_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_sel_q, rd_sel_d;
`ifdef TXACL_FLUSH_EN
    logic [15:0]   cnt_q, cnt_d;
    logic          flush_q, flush_d;
`endif

    // ------------------------------------------------------------------
    // Fill-side qualification
    // ------------------------------------------------------------------
    logic fill_sel;
    logic fill_full;
    logic done_ok;
    logic fill_full_eff;
    logic rx_slot;
    logic ack;
    logic release_pkt;
    logic nak;

    assign fill_sel      = ~txsel_q;
    assign fill_full     = full_q[fill_sel];
    // A done pulse only counts while the fill bank is still open
    assign done_ok       = bsm_wr_done_p & ~fill_full;
    // Fill bank full now or becoming full this cycle; lets a swap happen
    // in the same cycle as the done pulse
    assign fill_full_eff = fill_full | done_ok;
    assign rx_slot       = ms_tslot_p & ~pk_encode;
    assign ack           = dec_hecgood & dec_arqn;

    // ------------------------------------------------------------------
    // SRAM banks: the fill bank sees the bsm port, the tx bank the lnctrl
    // port. Writes into a full fill bank are suppressed.
    // ------------------------------------------------------------------
    logic [1:0]    bank_cs;
    logic [1:0]    bank_we;
    logic [AW-1:0] bank_addr [2];
    logic [31:0]   bank_dout [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic is_fill;
            assign is_fill       = (txsel_q != 1'(gi));
            assign bank_we[gi]   = is_fill & bsm_we & ~full_q[gi];
            assign bank_cs[gi]   = is_fill ? bank_we[gi] : lnctrl_cs;
            assign bank_addr[gi] = is_fill ? bsm_addr : lnctrl_addr;

            sram256x32_1p u_sram (
                .clk  (clk_6M),
                .cs   (bank_cs[gi]),
                .we   (bank_we[gi]),
                .addr (bank_addr[gi]),
                .din  (bsm_din),
                .dout (bank_dout[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        txsel_d     = txsel_q;
        full_d      = full_q;
        len_d       = len_q;
        seqn_d      = seqn_q;
        retx_d      = retx_q;
        rd_vld_d    = lnctrl_cs;
        // Remember which bank served the read so the data stays attached
        // to it even if the banks swap on the same edge
        rd_sel_d    = txsel_q;
        release_pkt = 1'b0;
        nak         = 1'b0;
`ifdef TXACL_FLUSH_EN
        cnt_d       = cnt_q;
        flush_d     = 1'b0;
`endif

        if (done_ok) begin
            full_d[fill_sel] = 1'b1;
            len_d[fill_sel]  = bsm_pylenByte;
        end

        case (state_q)
            ST_IDLE: begin
                if (fill_full_eff) begin
                    txsel_d = ~txsel_q;
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (lnctrl_tx_done_p) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (rx_slot) begin
                    if (ack) begin
                        release_pkt = 1'b1;
                    end else begin
                        nak = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef TXACL_FLUSH_EN
        // Count RX slots spent on the current packet; hitting the timeout
        // drops the packet and overrides any NAK seen in the same slot
        if ((state_q != ST_IDLE) && rx_slot) begin
            cnt_d = cnt_q + 16'd1;
            if ((regi_flushto != 16'd0) && (cnt_d == regi_flushto)) begin
                release_pkt = 1'b1;
                flush_d     = 1'b1;
            end
        end
`endif

        if (release_pkt) begin
            full_d[txsel_q] = 1'b0;
            seqn_d          = ~seqn_q;
            retx_d          = 1'b0;
            if (fill_full_eff) begin
                txsel_d = ~txsel_q;
                state_d = ST_READY;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (nak) begin
            state_d = ST_READY;
            retx_d  = 1'b1;
        end

`ifdef TXACL_FLUSH_EN
        // A fresh packet entering READY restarts its timeout
        if ((state_d == ST_READY) && ((state_q == ST_IDLE) || release_pkt)) begin
            cnt_d = 16'd0;
        end
`endif

        valid_d = (state_d == ST_READY);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            txsel_q  <= 1'b0;
            full_q   <= 2'b00;
            len_q    <= '{default: '0};
            seqn_q   <= 1'b1;
            retx_q   <= 1'b0;
            valid_q  <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_sel_q <= 1'b0;
`ifdef TXACL_FLUSH_EN
            cnt_q    <= 16'd0;
            flush_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            txsel_q  <= txsel_d;
            full_q   <= full_d;
            len_q    <= len_d;
            seqn_q   <= seqn_d;
            retx_q   <= retx_d;
            valid_q  <= valid_d;
            rd_vld_q <= rd_vld_d;
            rd_sel_q <= rd_sel_d;
`ifdef TXACL_FLUSH_EN
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // SRAM output register has no reset; gate it so idle cycles read 0
    assign lnctrl_dout        = rd_vld_q ? bank_dout[rd_sel_q] : 32'd0;
    assign txbuf_valid        = valid_q;
    assign tx_pylenByte       = full_q[txsel_q] ? len_q[txsel_q] : '0;
    assign tx_seqn            = seqn_q;
    assign tx_retx            = retx_q;
    assign regi_acltxbufempty = ~full_q[0] & ~full_q[1];
    assign regi_acltxbuffull  = full_q[0] & full_q[1];
`ifdef TXACL_FLUSH_EN
    assign flush_p            = flush_q;
`endif

endmodule : py_tx_acl_buf_ctrl
